// File: rtl/voting_machine_n.sv
// N-candidate voting machine: debounced buttons, saturating tallies, LED confirmation, winner scan.
// Optional VOTING_TOTAL_EN adds o_total_votes and shows the vote total on the LEDs when all buttons are released in results mode.
module voting_machine_n #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int DEBOUNCE = 10,
  parameter int LED_HOLD = 10,
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_mode,
  input  logic [NUM_CAND-1:0]    i_button,
  input  logic                   i_clear_tally,
`ifdef VOTING_TOTAL_EN
  output logic [CNT_W+IDX_W-1:0] o_total_votes,
`endif
  output logic [CNT_W-1:0]       o_leds,
  output logic [IDX_W-1:0]       o_winner_idx,
  output logic                   o_winner_valid,
  output logic                   o_tie,
  output logic                   o_reject
);

  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int HOLD_W = $clog2(LED_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  logic [DB_W-1:0]     r_db_cnt [NUM_CAND];
  logic [NUM_CAND-1:0] r_lock;
  logic [CNT_W-1:0]    r_tally [NUM_CAND];
  logic [HOLD_W-1:0]   r_hold;
  logic [CNT_W-1:0]    r_leds;
  logic                r_reject;
  logic                r_mode_q;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_scan_i;
  logic [CNT_W-1:0]    r_best;
  logic [IDX_W-1:0]    r_win;
  logic                r_tie;

  logic [NUM_CAND-1:0] w_press;
  logic [IDX_W-1:0]    w_press_idx;
  logic                w_any_press;
  logic                w_multi;
  logic                w_accept;
  logic                w_clear;
  logic                w_mode_rise;
  logic                w_mode_chg;
  logic                w_start;

  // A press is the single cycle in which a channel's count has just reached DEBOUNCE.
  always_comb begin
    w_press = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      w_press[i] = (r_db_cnt[i] == DB_W'(DEBOUNCE)) && !r_lock[i];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CAND; i++) r_db_cnt[i] <= '0;
      r_lock <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) begin
        if (!i_button[i]) begin
          r_db_cnt[i] <= '0;
          r_lock[i]   <= 1'b0;
        end else begin
          if (r_db_cnt[i] != DB_W'(DEBOUNCE)) r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
          if (w_press[i]) r_lock[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_press_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (w_press[i]) w_press_idx = IDX_W'(i);
    end
  end

  assign w_any_press = |w_press;
  assign w_multi     = (w_press & (w_press - NUM_CAND'(1))) != '0;
  assign w_accept    = !i_mode && w_any_press && !w_multi;
  assign w_clear     = i_mode && i_clear_tally;
  assign w_mode_rise = i_mode && !r_mode_q;
  assign w_mode_chg  = i_mode != r_mode_q;
  assign w_start     = w_clear || w_mode_rise;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mode_q <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_mode_q <= i_mode;
      r_reject <= !i_mode && w_multi;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || w_clear) begin
      for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
    end else if (w_accept && (r_tally[w_press_idx] != '1)) begin
      r_tally[w_press_idx] <= r_tally[w_press_idx] + CNT_W'(1);
    end
  end

`ifdef VOTING_TOTAL_EN
  logic [CNT_W+IDX_W-1:0] r_total;
  logic [CNT_W+IDX_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CAND; i++) w_sum = w_sum + (CNT_W+IDX_W)'(r_tally[i]);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_total <= '0;
    else         r_total <= w_sum;
  end

  assign o_total_votes = r_total;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset || w_mode_chg) begin
      r_hold <= '0;
      r_leds <= '0;
    end else if (!i_mode) begin
      if (w_accept) begin
        r_hold <= HOLD_W'(LED_HOLD);
        r_leds <= '1;
      end else if (r_hold > HOLD_W'(1)) begin
        r_hold <= r_hold - HOLD_W'(1);
        r_leds <= '1;
      end else begin
        r_hold <= '0;
        r_leds <= '0;
      end
    end else begin
      if (w_clear)          r_leds <= '0;
      else if (w_any_press) r_leds <= r_tally[w_press_idx];
`ifdef VOTING_TOTAL_EN
      else if (i_button == '0) r_leds <= r_total[CNT_W-1:0];
`endif
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_SCAN;
      S_SCAN: begin
        if (!i_mode)                               w_state_nxt = S_IDLE;
        else if (w_start)                          w_state_nxt = S_SCAN;
        else if (r_scan_i == IDX_W'(NUM_CAND - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!i_mode)      w_state_nxt = S_IDLE;
        else if (w_start) w_state_nxt = S_SCAN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A clear zeroes the tallies on this same edge, so the scan must seed best with 0.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_scan_i <= '0;
      r_best   <= '0;
      r_win    <= '0;
      r_tie    <= 1'b0;
    end else if (w_start) begin
      r_scan_i <= IDX_W'(1);
      r_best   <= w_clear ? '0 : r_tally[0];
      r_win    <= '0;
      r_tie    <= 1'b0;
    end else if (r_state == S_SCAN) begin
      if (r_tally[r_scan_i] > r_best) begin
        r_best <= r_tally[r_scan_i];
        r_win  <= r_scan_i;
        r_tie  <= 1'b0;
      end else if (r_tally[r_scan_i] == r_best) begin
        r_tie  <= 1'b1;
      end
      r_scan_i <= r_scan_i + IDX_W'(1);
    end
  end

  assign o_leds         = r_leds;
  assign o_reject       = r_reject;
  assign o_winner_idx   = r_win;
  assign o_tie          = r_tie;
  assign o_winner_valid = (r_state == S_DONE);

endmodule

// File: tb/tb_voting_machine_n.sv
// Testbench for voting_machine_n: directed plan scenarios plus random button/mode traffic,
// all checked every cycle against a vote-counting reference model.
module tb_voting_machine_n;
  localparam int NC    = 4;
  localparam int CW    = 8;
  localparam int DEB   = 10;
  localparam int HOLD  = 10;
  localparam int IW    = 2;
  localparam int MAXT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic [NC-1:0] btn = '0;
  logic          clr = 1'b0;
  logic [CW-1:0] o_leds;
  logic [IW-1:0] o_winner_idx;
  logic          o_winner_valid;
  logic          o_tie;
  logic          o_reject;

  voting_machine_n #(.NUM_CAND(NC), .CNT_W(CW), .DEBOUNCE(DEB), .LED_HOLD(HOLD), .IDX_W(IW)) dut (
    .i_clock(clk), .i_reset(rst), .i_mode(mode), .i_button(btn), .i_clear_tally(clr),
    .o_leds(o_leds), .o_winner_idx(o_winner_idx), .o_winner_valid(o_winner_valid),
    .o_tie(o_tie), .o_reject(o_reject)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: high-run length per button, vote counts, LED hold time, winner timing.
  int run   [NC];
  int tally [NC];
  int hold;
  int exp_leds;
  bit exp_reject;
  bit mode_prev;
  bit scanning;
  int cd;
  bit exp_valid;
  int exp_idx;
  bit exp_tie;
  bit wt_known;

  task automatic compute_winner();
    int mx, cnt;
    mx = -1; cnt = 0; exp_idx = 0;
    for (int i = 0; i < NC; i++) if (tally[i] > mx) begin mx = tally[i]; exp_idx = i; end
    for (int i = 0; i < NC; i++) if (tally[i] == mx) cnt++;
    exp_tie = (cnt > 1);
  endtask

  task automatic model_edge();
    logic [NC-1:0] pr;
    int np, pidx;
    bit accept, start;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin run[i] = 0; tally[i] = 0; end
      hold = 0; exp_leds = 0; exp_reject = 0; mode_prev = 0;
      scanning = 0; cd = 0; exp_valid = 0; exp_idx = 0; exp_tie = 0; wt_known = 1;
      return;
    end
    pr = '0; np = 0; pidx = -1;
    for (int i = 0; i < NC; i++) begin
      pr[i] = (run[i] == DEB);
      if (pr[i]) begin np++; if (pidx < 0) pidx = i; end
      run[i] = btn[i] ? run[i] + 1 : 0;
    end
    accept     = !mode && (np == 1);
    exp_reject = !mode && (np >= 2);
    if (mode != mode_prev) begin
      hold = 0; exp_leds = 0;
    end else if (!mode) begin
      if (accept) hold = HOLD;
      else if (hold > 0) hold--;
      exp_leds = (hold > 0) ? MAXT : 0;
    end else if (clr) begin
      exp_leds = 0;
    end else if (np > 0) begin
      exp_leds = tally[pidx];
    end
    if (mode && clr) for (int i = 0; i < NC; i++) tally[i] = 0;
    else if (accept && tally[pidx] < MAXT) tally[pidx]++;
    start = mode && (!mode_prev || clr);
    if (!mode) begin
      scanning = 0; exp_valid = 0;
    end else if (start) begin
      scanning = 1; cd = NC - 1; exp_valid = 0; wt_known = 0;
      compute_winner();
    end else if (scanning) begin
      cd--;
      if (cd == 0) begin exp_valid = 1; scanning = 0; end
    end
    mode_prev = mode;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("leds", int'(o_leds), exp_leds);
    check_eq("reject", int'(o_reject), int'(exp_reject));
    check_eq("winner_valid", int'(o_winner_valid), int'(exp_valid));
    if (exp_valid || wt_known) begin
      check_eq("winner_idx", int'(o_winner_idx), exp_idx);
      check_eq("tie", int'(o_tie), int'(exp_tie));
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic vote(input int c);
    btn = '0; btn[c] = 1'b1;
    run_cycles(DEB);
    btn = '0;
    run_cycles(2);
  endtask

  initial begin
    rst = 1'b1;
    run_cycles(3);
    rst = 1'b0;
    run_cycles(2);

    // single press, then LED hold expiry
    btn = 4'b0100; run_cycles(DEB); btn = '0; run_cycles(15);
    // long hold yields one vote, then a second vote
    btn = 4'b0010; run_cycles(50); btn = '0; run_cycles(3);
    vote(1); run_cycles(12);
    // simultaneous presses are rejected
    btn = 4'b1001; run_cycles(DEB + 3); btn = '0; run_cycles(5);

    // saturation on candidate 0
    for (int v = 0; v < MAXT + 1; v++) vote(0);
    check_eq("sat_leds_on", int'(o_leds), MAXT);
    run_cycles(12);
    mode = 1'b1; run_cycles(2);
    btn = 4'b0001; run_cycles(DEB + 1); btn = '0; run_cycles(2);
    check_eq("sat_tally0", int'(o_leds), MAXT);
    mode = 1'b0; run_cycles(3);

    // tallies {3,5,5,1}
    rst = 1'b1; run_cycles(1); rst = 1'b0; run_cycles(1);
    for (int v = 0; v < 3; v++) vote(0);
    for (int v = 0; v < 5; v++) vote(1);
    for (int v = 0; v < 5; v++) vote(2);
    vote(3);
    run_cycles(12);
    mode = 1'b1;
    run_cycles(NC - 1);
    check_eq("plan_valid_early", int'(o_winner_valid), 0);
    run_cycles(1);
    check_eq("plan_valid", int'(o_winner_valid), 1);
    check_eq("plan_idx", int'(o_winner_idx), 1);
    check_eq("plan_tie", int'(o_tie), 1);
    btn = 4'b1000; run_cycles(DEB + 1); btn = '0; run_cycles(2);
    check_eq("plan_leds_t3", int'(o_leds), 1);

    // admin clear, rescan, then reset mid-scan
    clr = 1'b1; run_cycles(1); clr = 1'b0;
    check_eq("clr_valid_drop", int'(o_winner_valid), 0);
    run_cycles(NC + 1);
    check_eq("clr_valid", int'(o_winner_valid), 1);
    check_eq("clr_idx", int'(o_winner_idx), 0);
    check_eq("clr_tie", int'(o_tie), 1);
    clr = 1'b1; run_cycles(1); clr = 1'b0; run_cycles(1);
    rst = 1'b1; run_cycles(1); rst = 1'b0;
    check_eq("rst_mid_valid", int'(o_winner_valid), 0);
    check_eq("rst_mid_leds", int'(o_leds), 0);
    mode = 1'b0; run_cycles(3);

    // random traffic
    for (int seg = 0; seg < 400; seg++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1'b1; run_cycles(1); rst = 1'b0;
      end else if (r < 12) begin
        mode = ~mode; run_cycles($urandom_range(1, 12));
      end else if (r < 16) begin
        clr = 1'b1; run_cycles(1); clr = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) btn = NC'($urandom);
        else if ($urandom_range(0, 4) == 0) btn = '0;
        else begin btn = '0; btn[$urandom_range(0, NC - 1)] = 1'b1; end
        run_cycles($urandom_range(1, 25));
      end
    end
    btn = '0; mode = 1'b0; run_cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/voting_machine_n.md
Name: voting_machine_n

Overview:
Parametrised N-candidate electronic voting machine: per-button debounce with press lockout, saturating tally counters, multi-press rejection, LED vote confirmation, results display, and a sequential winner-scan FSM. Top-level block driven directly by board buttons and a mode switch; drives the LED bank.

Parameters:
NUM_CAND, 4, number of candidates/buttons (2..16)
CNT_W, 8, tally width per candidate; also LED bank width
DEBOUNCE, 10, consecutive high cycles required to register a press (>=1)
LED_HOLD, 10, cycles LEDs stay all-ones after an accepted vote (>=1)
IDX_W, $clog2(NUM_CAND), candidate index width

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
mode  in  1  0 = voting, 1 = results
button  in  NUM_CAND  raw candidate buttons, bit i = candidate i, pre-synchronised
clear_tally  in  1  admin clear of all tallies; honoured only when mode=1
leds  out  CNT_W  confirmation pattern or selected tally
winner_idx  out  IDX_W  index of highest tally
winner_valid  out  1  winner_idx/tie valid for current tallies
tie  out  1  highest tally shared by >1 candidate
reject  out  1  one-cycle pulse: simultaneous presses discarded

Behaviour:
- Reset: all tallies 0, debounce counters 0, lockouts clear, leds=0, winner_idx=0, winner_valid=0, tie=0, reject=0, FSM IDLE, LED hold counter 0.
- Debounce per channel i: counter increments while button[i]=1, saturates at DEBOUNCE; counter reaching DEBOUNCE emits press_i for exactly one cycle and sets lockout_i. button[i]=0 clears counter and lockout_i. Holding a button yields one press only.
- Accept (mode=0 only): exactly one press_i in a cycle -> tally[i] += 1 on next edge. Two or more simultaneous press pulses -> no tally changes, reject=1 for one cycle. press_i in mode=1 never alters tallies.
- Saturation: tally at 2^CNT_W-1 stays there; press still counts as accepted (LED confirmation fires).
- LED, mode=0: accepted vote loads hold counter with LED_HOLD; while counter>0 leds=all ones, decrement each cycle; a new accepted vote during hold reloads to LED_HOLD; otherwise leds=0. Rejected press does not light LEDs.
- LED, mode=1: press_i latches leds=tally[i]; value held until another press or mode change. Entering mode=1 sets leds=0; entering mode=0 sets leds=0 and clears the hold counter.
- clear_tally=1 with mode=1: all tallies 0 next edge, winner_valid=0, leds=0, FSM restarts scan. Ignored in mode=0.
- Winner FSM states IDLE, SCAN, DONE:
  IDLE: winner_valid=0; mode rises 0->1 (or clear_tally in mode=1) -> SCAN, index=0, best=tally[0], winner_idx=0, tie=0.
  SCAN: one candidate per cycle, i=1..NUM_CAND-1; tally[i]>best -> best=tally[i], winner_idx=i, tie=0; tally[i]==best -> tie=1 (winner_idx keeps lowest index). After last index -> DONE.
  DONE: winner_valid=1; mode=0 -> IDLE.
  Latency: winner_valid rises NUM_CAND cycles after entering SCAN.
  mode=0 during SCAN -> IDLE immediately, outputs invalid.
- All tallies zero: winner_idx=0, tie=1, winner_valid=1.
- Reset mid-operation (any state, mid-debounce, mid-hold) returns to reset values next edge.

Optional Feature:
Macro VOTING_TOTAL_EN. Defined: extra output total_votes (CNT_W+IDX_W bits) = registered sum of all tallies, updated the cycle after each accepted vote or clear; reset 0; in mode=1 with every button released for one cycle, leds shows low CNT_W bits of total_votes. Undefined: port absent, no adder, leds behaviour as above.

Test Plan:
- Reset, mode=0, button[2] high 10 cycles then low -> press on cycle 10, tally2=1, leds=FF for 10 cycles, then 00; other tallies 0.
- button[1] held 50 cycles -> tally1=1 only; release, press again 10 cycles -> tally1=2.
- button[0] and button[3] rise same cycle, held 10 -> reject pulse 1 cycle, all tallies unchanged, leds stay 00.
- 255 accepted votes on candidate 0 then one more -> tally0 stays 255, LED confirmation still shown.
- Tallies {3,5,5,1}, mode 0->1 -> after 4 cycles winner_valid=1, winner_idx=1, tie=1; button[3] press -> leds=01.
- mode=1, clear_tally pulse -> all tallies 0, winner_valid drops then rises with winner_idx=0, tie=1; reset asserted mid-SCAN -> all outputs 0 next edge.
